// File: rtl/triangle_sequencer_if.sv
// ---------------------------------------------------------------------------
// triangle_sequencer_if
// Groups the scene-store read bus and the renderer handshake of the
// triangle sequencer.
//   mem_addr       scene store read address          (master -> slave)
//   mem_data       scene store read data             (slave  -> master)
//   render_rst     one-cycle renderer reset pulse    (master -> slave)
//   triangle       128-bit triangle word             (master -> slave)
//   triangle_valid qualifies triangle                (master -> slave)
//   render_active  renderer start/hold level         (master -> slave)
//   render_done    renderer frame-complete pulse     (slave  -> master)
// The master modport is the sequencer; the slave modport is the scene
// store plus renderer.
// ---------------------------------------------------------------------------
interface triangle_sequencer_if #(
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [127:0]          mem_data;
  logic                  render_rst;
  logic [127:0]          triangle;
  logic                  triangle_valid;
  logic                  render_active;
  logic                  render_done;

  modport master (
    output mem_addr, render_rst, triangle, triangle_valid, render_active,
    input  mem_data, render_done
  );

  modport slave (
    input  mem_addr, render_rst, triangle, triangle_valid, render_active,
    output mem_data, render_done
  );
endinterface

// File: rtl/triangle_sequencer.sv
// ---------------------------------------------------------------------------
// triangle_sequencer
// Per-frame feeder for the renderer: pulses render_rst, streams up to
// MAX_TRIANGLES 128-bit triangle words out of a scene store with
// READ_LATENCY cycles of read latency, arms rendering, waits for
// render_done and counts completed frames.
// Ports:
//   clk            render-domain clock
//   rst            asynchronous active-high reset
//   enable         level, high = run frames back to back
//   num_triangles  scene size, sampled in PULSE, clamped to MAX_TRIANGLES
//   tri_mask       per-word valid gate (only with TRI_MASK_EN)
//   bus            scene store / renderer interface (master side)
//   frame_done     one-cycle pulse per completed frame
//   frame_count    completed frames, wraps
//   busy           high whenever the FSM is not IDLE
// Optional feature macro: TRI_MASK_EN adds tri_mask; masked words keep
// their read timing but are not flagged valid.
// ---------------------------------------------------------------------------
module triangle_sequencer #(
  parameter int MAX_TRIANGLES = 64,
  parameter int ADDR_WIDTH    = $clog2(MAX_TRIANGLES),
  parameter int READ_LATENCY  = 2,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [ADDR_WIDTH:0]      num_triangles,
`ifdef TRI_MASK_EN
  input  logic [MAX_TRIANGLES-1:0] tri_mask,
`endif
  triangle_sequencer_if.master     bus,
  output logic                     frame_done,
  output logic [COUNT_WIDTH-1:0]   frame_count,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE, PULSE, STREAM, DRAIN, ARM, RENDERING, DONE
  } state_e;

  localparam logic [ADDR_WIDTH:0] MAX_N = (ADDR_WIDTH+1)'(MAX_TRIANGLES);

  state_e                    state_r, state_next_s;
  logic [ADDR_WIDTH:0]       n_r, n_clamp_s;
  logic [ADDR_WIDTH-1:0]     mem_addr_r;
  logic                      addr_vld_r;
  logic [READ_LATENCY-1:0]   pipe_r;
  logic                      last_addr_s, pipe_empty_s, word_valid_s;
  logic [127:0]              triangle_r;
  logic                      triangle_valid_r, render_rst_r, render_active_r;
  logic                      frame_done_r;
  logic [COUNT_WIDTH-1:0]    frame_count_r;
`ifdef TRI_MASK_EN
  logic [MAX_TRIANGLES-1:0]  tri_mask_r;
  logic [ADDR_WIDTH-1:0]     out_idx_r;
`endif

  // Clamp the requested scene size and derive stream/drain conditions.
  always_comb begin
    if (num_triangles > MAX_N) begin
      n_clamp_s = MAX_N;
    end else begin
      n_clamp_s = num_triangles;
    end
    last_addr_s  = ({1'b0, mem_addr_r} == (n_r - (ADDR_WIDTH+1)'(1)));
    // The last word is on triangle in the cycle the shift register empties.
    pipe_empty_s = !addr_vld_r && (pipe_r == {READ_LATENCY{1'b0}});
`ifdef TRI_MASK_EN
    word_valid_s = pipe_r[READ_LATENCY-1] & tri_mask_r[out_idx_r];
`else
    word_valid_s = pipe_r[READ_LATENCY-1];
`endif
  end

  // Next-state logic of the frame FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_next_s = PULSE;
        else        state_next_s = IDLE;
      end
      PULSE: begin
        if (n_clamp_s == (ADDR_WIDTH+1)'(0)) state_next_s = ARM;
        else                                 state_next_s = STREAM;
      end
      STREAM: begin
        if (last_addr_s) state_next_s = DRAIN;
        else             state_next_s = STREAM;
      end
      DRAIN: begin
        if (pipe_empty_s) state_next_s = ARM;
        else              state_next_s = DRAIN;
      end
      ARM:       state_next_s = RENDERING;
      RENDERING: begin
        if (bus.render_done) state_next_s = DONE;
        else                 state_next_s = RENDERING;
      end
      DONE:      state_next_s = IDLE;
      default:   state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Datapath and registered outputs, decoded from the next state so each
  // output is valid in the same cycle as the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r              <= '0;
      mem_addr_r       <= '0;
      addr_vld_r       <= 1'b0;
      pipe_r           <= '0;
      triangle_r       <= '0;
      triangle_valid_r <= 1'b0;
      render_rst_r     <= 1'b0;
      render_active_r  <= 1'b0;
      frame_done_r     <= 1'b0;
      frame_count_r    <= '0;
`ifdef TRI_MASK_EN
      tri_mask_r       <= '0;
      out_idx_r        <= '0;
`endif
    end else begin
      render_rst_r    <= (state_next_s == PULSE);
      render_active_r <= (state_next_s == RENDERING);
      frame_done_r    <= (state_next_s == DONE);
      if (state_next_s == DONE) frame_count_r <= frame_count_r + COUNT_WIDTH'(1);
      if (state_r == PULSE) n_r <= n_clamp_s;
      addr_vld_r <= (state_next_s == STREAM);
      if (state_next_s == STREAM) begin
        if (state_r == PULSE) mem_addr_r <= '0;
        else                  mem_addr_r <= mem_addr_r + ADDR_WIDTH'(1);
      end
      // One valid bit per outstanding read; the last stage lines up with
      // mem_data for the matching address.
      pipe_r[0] <= addr_vld_r;
      for (int i = 1; i < READ_LATENCY; i++) pipe_r[i] <= pipe_r[i-1];
      triangle_valid_r <= word_valid_s;
      if (word_valid_s) triangle_r <= bus.mem_data;
`ifdef TRI_MASK_EN
      if (state_r == PULSE) begin
        tri_mask_r <= tri_mask;
        out_idx_r  <= '0;
      end else if (pipe_r[READ_LATENCY-1]) begin
        out_idx_r  <= out_idx_r + ADDR_WIDTH'(1);
      end
`endif
    end
  end

  assign bus.mem_addr       = mem_addr_r;
  assign bus.render_rst     = render_rst_r;
  assign bus.triangle       = triangle_r;
  assign bus.triangle_valid = triangle_valid_r;
  assign bus.render_active  = render_active_r;
  assign frame_done         = frame_done_r;
  assign frame_count        = frame_count_r;
  assign busy               = (state_r != IDLE);

endmodule

// File: tb/tb_triangle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_triangle_sequencer
// Directed bench for triangle_sequencer. The scene store is a two-stage
// registered ROM holding word k = k+1. A second instance with a 4-bit
// frame counter exercises counter wrap without running 65536 frames.
// ---------------------------------------------------------------------------
module tb_triangle_sequencer;

  logic        clk;
  logic        rst;
  logic        enable, enable2;
  logic [6:0]  num_triangles, num_triangles2;
  logic        frame_done, frame_done2;
  logic [15:0] frame_count;
  logic [3:0]  frame_count2;
  logic        busy, busy2;
`ifdef TRI_MASK_EN
  logic [63:0] tri_mask;
`endif

  triangle_sequencer_if #(.ADDR_WIDTH(6)) bus ();
  triangle_sequencer_if #(.ADDR_WIDTH(6)) bus2 ();

  triangle_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .num_triangles(num_triangles),
`ifdef TRI_MASK_EN
    .tri_mask(tri_mask),
`endif
    .bus(bus), .frame_done(frame_done), .frame_count(frame_count), .busy(busy)
  );

  triangle_sequencer #(.COUNT_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst), .enable(enable2), .num_triangles(num_triangles2),
`ifdef TRI_MASK_EN
    .tri_mask(tri_mask),
`endif
    .bus(bus2), .frame_done(frame_done2), .frame_count(frame_count2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output scene store, two cycles of read latency.
  logic [127:0] rom_q1;
  always @(posedge clk) begin
    rom_q1       <= 128'(bus.mem_addr) + 128'd1;
    bus.mem_data <= rom_q1;
  end
  assign bus2.mem_data = 128'd0;

  int n_vec = 0;
  int n_err = 0;
  int ref_act_rel = -1;
  logic [127:0] seen_data[$];

  // Runs from the current negedge until render_active is seen (or budget
  // expires), recording render_rst, addresses and the valid words.
  task automatic run_frame(input int budget, input int spur_at,
                           output int rst_cyc, output int rst_cnt,
                           output int first_addr, output int first_v,
                           output int last_v, output int act_cyc,
                           output int max_addr);
    seen_data.delete();
    rst_cyc = -1; rst_cnt = 0; first_addr = -1; first_v = -1;
    last_v = -1; act_cyc = -1; max_addr = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      bus.render_done = (c == spur_at);
      if (bus.render_rst) begin
        rst_cnt++;
        if (rst_cyc < 0) rst_cyc = c;
      end
      if (rst_cyc >= 0 && c == rst_cyc + 1) first_addr = int'(bus.mem_addr);
      if (rst_cyc >= 0 && c > rst_cyc && int'(bus.mem_addr) > max_addr)
        max_addr = int'(bus.mem_addr);
      if (bus.triangle_valid) begin
        seen_data.push_back(bus.triangle);
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (bus.render_active) begin
        act_cyc = c;
        break;
      end
    end
    bus.render_done = 1'b0;
  endtask

  // Finishes a frame that is sitting in RENDERING and lets it settle.
  task automatic end_frame();
    @(negedge clk); bus.render_done = 1'b1;
    @(negedge clk); bus.render_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; enable2 = 1'b0;
    num_triangles = 7'd0; num_triangles2 = 7'd0;
    bus.render_done = 1'b0; bus2.render_done = 1'b0;
`ifdef TRI_MASK_EN
    tri_mask = {64{1'b1}};
`endif
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.mem_addr, bus.triangle, bus.triangle_valid, bus.render_rst,
         bus.render_active, frame_done, frame_count, busy} !== 156'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got nonzero output (addr=%0d valid=%0b cnt=%0d busy=%0b), required all 0",
               bus.mem_addr, bus.triangle_valid, frame_count, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL idle_busy: got %0b required 0", busy);
    end
  endtask

  task automatic test_stream();
    int rc, rn, fa, fv, lv, ac, ma;
    num_triangles = 7'd6; enable = 1'b1;
    run_frame(60, -1, rc, rn, fa, fv, lv, ac, ma);
    n_vec++;
    if (rn !== 1) begin n_err++; $display("FAIL stream_rst_pulses: got %0d required 1", rn); end
    n_vec++;
    if (fa !== 0) begin n_err++; $display("FAIL stream_first_addr: got %0d required 0", fa); end
    n_vec++;
    if (seen_data.size() !== 6) begin
      n_err++; $display("FAIL stream_count: got %0d required 6", seen_data.size());
    end
    for (int k = 0; k < 6 && k < seen_data.size(); k++) begin
      n_vec++;
      if (seen_data[k] !== 128'(k + 1)) begin
        n_err++; $display("FAIL stream_data%0d: got %0h required %0h", k, seen_data[k], k + 1);
      end
    end
    n_vec++;
    if (fv - (rc + 1) !== 3) begin
      n_err++; $display("FAIL stream_latency: got %0d required 3", fv - (rc + 1));
    end
    n_vec++;
    if (lv - fv !== 5) begin n_err++; $display("FAIL stream_contiguous: got span %0d required 5", lv - fv); end
    n_vec++;
    if (!(ac > lv && lv >= 0)) begin
      n_err++; $display("FAIL stream_active_after_valid: got active %0d last valid %0d", ac, lv);
    end
  endtask

  task automatic test_render_done();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.render_active, frame_done} !== 2'b10) begin
      n_err++; $display("FAIL rendering_hold: got %b required 10", {bus.render_active, frame_done});
    end
    bus.render_done = 1'b1;
    @(negedge clk);
    bus.render_done = 1'b0;
    // Takes effect at the PULSE two cycles from now.
    num_triangles = 7'd0;
    n_vec++;
    if ({frame_done, bus.render_active, busy} !== 3'b101) begin
      n_err++; $display("FAIL done_state: got fd/act/busy=%b required 101", {frame_done, bus.render_active, busy});
    end
    n_vec++;
    if (frame_count !== 16'd1) begin n_err++; $display("FAIL done_count: got %0d required 1", frame_count); end
    @(negedge clk);
    n_vec++;
    if ({frame_done, busy} !== 2'b00) begin
      n_err++; $display("FAIL done_one_cycle: got fd/busy=%b required 00", {frame_done, busy});
    end
    @(negedge clk);
    n_vec++;
    if (bus.render_rst !== 1'b1) begin n_err++; $display("FAIL restart_pulse: got %0b required 1", bus.render_rst); end
  endtask

  task automatic test_zero();
    int rc, rn, fa, fv, lv, ac, ma;
    // Currently in PULSE with num_triangles=0 sampled.
    run_frame(20, -1, rc, rn, fa, fv, lv, ac, ma);
    n_vec++;
    if (seen_data.size() !== 0) begin n_err++; $display("FAIL zero_valid: got %0d required 0", seen_data.size()); end
    n_vec++;
    if (ac !== 1) begin n_err++; $display("FAIL zero_arm_timing: got %0d required 1", ac); end
    enable = 1'b0;
    end_frame();
    n_vec++;
    if (frame_count !== 16'd2) begin n_err++; $display("FAIL zero_count: got %0d required 2", frame_count); end
  endtask

  task automatic test_clamp();
    int rc, rn, fa, fv, lv, ac, ma;
    num_triangles = 7'd100; enable = 1'b1;
    run_frame(300, -1, rc, rn, fa, fv, lv, ac, ma);
    enable = 1'b0;
    n_vec++;
    if (seen_data.size() !== 64) begin n_err++; $display("FAIL clamp_count: got %0d required 64", seen_data.size()); end
    n_vec++;
    if (ma !== 63) begin n_err++; $display("FAIL clamp_max_addr: got %0d required 63", ma); end
    n_vec++;
    if (lv - fv !== 63) begin n_err++; $display("FAIL clamp_contiguous: got %0d required 63", lv - fv); end
    if (seen_data.size() == 64) begin
      n_vec++;
      if (seen_data[63] !== 128'd64) begin
        n_err++; $display("FAIL clamp_last_word: got %0h required 40", seen_data[63]);
      end
    end
    end_frame();
  endtask

  task automatic test_reset_mid();
    int rc, rn, fa, fv, lv, ac, ma;
    int found, vcnt;
    num_triangles = 7'd6; enable = 1'b1;
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      @(negedge clk);
      if (busy && bus.mem_addr == 6'd3 && !bus.render_rst) found = 1;
    end
    n_vec++;
    if (found !== 1) begin n_err++; $display("FAIL midrst_reach_stream: got %0d required 1", found); end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.mem_addr, bus.triangle, bus.triangle_valid, bus.render_rst,
         bus.render_active, frame_done, frame_count, busy} !== 156'd0) begin
      n_err++; $display("FAIL midrst_outputs: got addr=%0d valid=%0b cnt=%0d busy=%0b required all 0",
                        bus.mem_addr, bus.triangle_valid, frame_count, busy);
    end
    vcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.triangle_valid) vcnt++;
    end
    n_vec++;
    if (vcnt !== 0) begin n_err++; $display("FAIL midrst_no_valid: got %0d required 0", vcnt); end
    rst = 1'b0;
    run_frame(60, -1, rc, rn, fa, fv, lv, ac, ma);
    n_vec++;
    if (fa !== 0) begin n_err++; $display("FAIL midrst_restart_addr: got %0d required 0", fa); end
    n_vec++;
    if (seen_data.size() !== 6) begin n_err++; $display("FAIL midrst_count: got %0d required 6", seen_data.size()); end
    n_vec++;
    if (seen_data.size() == 0 || seen_data[0] !== 128'd1) begin
      n_err++; $display("FAIL midrst_first_word: got %0d words, required first word 1", seen_data.size());
    end
    enable = 1'b0;
    end_frame();
    n_vec++;
    if (frame_count !== 16'd1) begin n_err++; $display("FAIL midrst_count_after: got %0d required 1", frame_count); end
  endtask

  task automatic test_spurious_and_stop();
    int rc, rn, fa, fv, lv, ac, ma;
    int bad;
    num_triangles = 7'd4; enable = 1'b1;
    run_frame(60, 3, rc, rn, fa, fv, lv, ac, ma);
    ref_act_rel = ac - rc;
    n_vec++;
    if (seen_data.size() !== 4) begin n_err++; $display("FAIL spur_count: got %0d required 4", seen_data.size()); end
    n_vec++;
    if (fv - rc !== 4) begin n_err++; $display("FAIL spur_first_valid: got %0d required 4", fv - rc); end
    n_vec++;
    if (!(ac > lv && lv >= 0)) begin n_err++; $display("FAIL spur_active: got active %0d last valid %0d", ac, lv); end
    n_vec++;
    if (frame_count !== 16'd1) begin n_err++; $display("FAIL spur_ignored: got count %0d required 1", frame_count); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.render_active, busy} !== 2'b11) begin
      n_err++; $display("FAIL stop_still_rendering: got %b required 11", {bus.render_active, busy});
    end
    bus.render_done = 1'b1;
    @(negedge clk);
    bus.render_done = 1'b0;
    n_vec++;
    if ({frame_done, frame_count} !== {1'b1, 16'd2}) begin
      n_err++; $display("FAIL stop_done: got fd=%0b cnt=%0d required fd=1 cnt=2", frame_done, frame_count);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || bus.render_rst) bad++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL stop_idle: got %0d busy cycles required 0", bad); end
  endtask

`ifdef TRI_MASK_EN
  task automatic test_mask();
    int rc, rn, fa, fv, lv, ac, ma;
    tri_mask = 64'hA; num_triangles = 7'd4; enable = 1'b1;
    run_frame(60, -1, rc, rn, fa, fv, lv, ac, ma);
    enable = 1'b0;
    n_vec++;
    if (seen_data.size() !== 2) begin n_err++; $display("FAIL mask_count: got %0d required 2", seen_data.size()); end
    n_vec++;
    if (seen_data.size() != 2 || seen_data[0] !== 128'd2 || seen_data[1] !== 128'd4) begin
      n_err++; $display("FAIL mask_words: got %0d words, required words 2 and 4", seen_data.size());
    end
    n_vec++;
    if (fv - rc !== 5) begin n_err++; $display("FAIL mask_first_valid: got %0d required 5", fv - rc); end
    n_vec++;
    if (ac - rc !== ref_act_rel) begin
      n_err++; $display("FAIL mask_active_timing: got %0d required %0d", ac - rc, ref_act_rel);
    end
    end_frame();
    tri_mask = {64{1'b1}};
  endtask
`endif

  task automatic test_wrap();
    int fd, act;
    fd = 0; act = 0;
    num_triangles2 = 7'd0;
    // render_done held high also covers a done pulse coinciding with ARM.
    bus2.render_done = 1'b1;
    enable2 = 1'b1;
    for (int c = 0; c < 200 && fd < 16; c++) begin
      @(negedge clk);
      if (bus2.render_active) act++;
      if (frame_done2) begin
        fd++;
        if (fd == 15) begin
          n_vec++;
          if (frame_count2 !== 4'hF) begin n_err++; $display("FAIL wrap_max: got %0d required 15", frame_count2); end
        end
        if (fd == 16) begin
          enable2 = 1'b0;
          n_vec++;
          if (frame_count2 !== 4'h0) begin n_err++; $display("FAIL wrap_zero: got %0d required 0", frame_count2); end
        end
      end
    end
    bus2.render_done = 1'b0;
    n_vec++;
    if (fd !== 16) begin n_err++; $display("FAIL wrap_frames: got %0d required 16", fd); end
    n_vec++;
    if (act !== 16) begin n_err++; $display("FAIL wrap_rendering_entered: got %0d required 16", act); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_render_done();
    test_zero();
    test_clamp();
    test_reset_mid();
    test_spurious_and_stop();
`ifdef TRI_MASK_EN
    test_mask();
`endif
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
